// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Merges the core's instruction and data memory ports onto one unified
// memory port. Requests are granted round-robin. A small in-order tag FIFO
// records which port issued each in-flight request, so every response
// (memory answers strictly in order) is steered back to the right port.
module core_mem_arbiter #(
    parameter int REQ_SZ    = 67,
    parameter int RESP_SZ   = 35,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [REQ_SZ-1:0]          imemreq_msg,
    input  logic                       imemreq_val,
    output logic                       imemreq_rdy,
    output logic [RESP_SZ-1:0]         imemresp_msg,
    output logic                       imemresp_val,

    input  logic [REQ_SZ-1:0]          dmemreq_msg,
    input  logic                       dmemreq_val,
    output logic                       dmemreq_rdy,
    output logic [RESP_SZ-1:0]         dmemresp_msg,
    output logic                       dmemresp_val,

    output logic [REQ_SZ-1:0]          memreq_msg,
    output logic                       memreq_val,
    input  logic                       memreq_rdy,
    input  logic [RESP_SZ-1:0]         memresp_msg,
    input  logic                       memresp_val,

    output logic [$clog2(MAX_OUTST):0] num_outst,
    output logic                       resp_err
);

    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = $clog2(MAX_OUTST) + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

    // prio_q: 1 = dmem has priority, 0 = imem has priority
    logic                 prio_q;
    // One tag bit per in-flight request: 1 = dmem, 0 = imem
    logic [MAX_OUTST-1:0] tag_q;
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [CW-1:0]        count_q;
    logic                 resp_err_q;

    logic full;
    logic empty;
    logic grant_dmem;
    logic push;
    logic pop;
    logic head_tag;

    // Request side: pick a winner, pass its message through, and hand the
    // memory-side ready back only to the winner while the tag FIFO has room.
    always_comb begin
        full        = (count_q == CNT_MAX);
        empty       = (count_q == '0);
        grant_dmem  = 1'b1;
        memreq_msg  = dmemreq_msg;
        memreq_val  = 1'b0;
        imemreq_rdy = 1'b0;
        dmemreq_rdy = 1'b0;
        push        = 1'b0;

        if (imemreq_val && dmemreq_val) begin
            grant_dmem = prio_q;
        end else begin
            grant_dmem = !imemreq_val;
        end

        memreq_msg = grant_dmem ? dmemreq_msg : imemreq_msg;

        if (!reset && !full) begin
            memreq_val  = grant_dmem ? dmemreq_val : imemreq_val;
            dmemreq_rdy = memreq_rdy && grant_dmem;
            imemreq_rdy = memreq_rdy && !grant_dmem;
        end

        push = memreq_val && memreq_rdy;
    end

    // Response side: the oldest tag decides which port sees the response;
    // a response with nothing outstanding is dropped.
    always_comb begin
        head_tag     = tag_q[head_q];
        pop          = !reset && memresp_val && !empty;
        imemresp_msg = memresp_msg;
        dmemresp_msg = memresp_msg;
        imemresp_val = pop && !head_tag;
        dmemresp_val = pop && head_tag;
        num_outst    = reset ? '0 : count_q;
        resp_err     = !reset && resp_err_q;
    end

    // State update: priority rotation, tag FIFO pointers/occupancy, and the
    // sticky error flag for unexpected responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[tail_q] <= grant_dmem;
                tail_q        <= tail_q + PTR_ONE;
                prio_q        <= !grant_dmem;
            end

            if (pop) begin
                head_q <= head_q + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase

            if (memresp_val && empty) begin
                resp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter
// Directed bench for core_mem_arbiter. Inputs change on the falling edge,
// combinational outputs are sampled 1ns later, registered effects are
// sampled on the following falling edge.
module tb_core_mem_arbiter;

    localparam int REQ_SZ    = 67;
    localparam int RESP_SZ   = 35;
    localparam int MAX_OUTST = 4;

    logic                       clk;
    logic                       reset;
    logic [REQ_SZ-1:0]          imemreq_msg;
    logic                       imemreq_val;
    logic                       imemreq_rdy;
    logic [RESP_SZ-1:0]         imemresp_msg;
    logic                       imemresp_val;
    logic [REQ_SZ-1:0]          dmemreq_msg;
    logic                       dmemreq_val;
    logic                       dmemreq_rdy;
    logic [RESP_SZ-1:0]         dmemresp_msg;
    logic                       dmemresp_val;
    logic [REQ_SZ-1:0]          memreq_msg;
    logic                       memreq_val;
    logic                       memreq_rdy;
    logic [RESP_SZ-1:0]         memresp_msg;
    logic                       memresp_val;
    logic [$clog2(MAX_OUTST):0] num_outst;
    logic                       resp_err;

    int checks;
    int failures;

    core_mem_arbiter #(
        .REQ_SZ    (REQ_SZ),
        .RESP_SZ   (RESP_SZ),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imemreq_msg  (imemreq_msg),
        .imemreq_val  (imemreq_val),
        .imemreq_rdy  (imemreq_rdy),
        .imemresp_msg (imemresp_msg),
        .imemresp_val (imemresp_val),
        .dmemreq_msg  (dmemreq_msg),
        .dmemreq_val  (dmemreq_val),
        .dmemreq_rdy  (dmemreq_rdy),
        .dmemresp_msg (dmemresp_msg),
        .dmemresp_val (dmemresp_val),
        .memreq_msg   (memreq_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memresp_msg  (memresp_msg),
        .memresp_val  (memresp_val),
        .num_outst    (num_outst),
        .resp_err     (resp_err)
    );

    // Free-running clock, 10ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request layout {type, addr[31:0], len[1:0], data[31:0]}
    function automatic logic [REQ_SZ-1:0] mk_req(input logic typ, input logic [31:0] addr, input logic [31:0] data);
        return {typ, addr, 2'b00, data};
    endfunction

    // Response layout {type, len[1:0], data[31:0]}
    function automatic logic [RESP_SZ-1:0] mk_resp(input logic [31:0] data);
        return {1'b0, 2'b00, data};
    endfunction

    task automatic idle_inputs();
        imemreq_msg = '0;
        imemreq_val = 1'b0;
        dmemreq_msg = '0;
        dmemreq_val = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_msg = '0;
        memresp_val = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (memreq_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_memreq_val got=%b exp=0", memreq_val); end
        checks++; if ({imemreq_rdy, dmemreq_rdy} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rdys got=%b exp=00", {imemreq_rdy, dmemreq_rdy}); end
        checks++; if ({imemresp_val, dmemresp_val} !== 2'b00) begin failures++; $display("[TB] FAIL reset_resp_vals got=%b exp=00", {imemresp_val, dmemresp_val}); end
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL reset_num_outst got=%0d exp=0", num_outst); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_err got=%b exp=0", resp_err); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
    endtask

    // Single imem request and its response; prio ends at dmem
    task automatic test_single_imem();
        logic [REQ_SZ-1:0] req;
        req = mk_req(1'b0, 32'h0000_1000, 32'h0);
        imemreq_msg = req;
        imemreq_val = 1'b1;
        memreq_rdy  = 1'b1;
        #1;
        checks++; if (memreq_val !== 1'b1) begin failures++; $display("[TB] FAIL single_memreq_val got=%b exp=1", memreq_val); end
        checks++; if (memreq_msg !== req) begin failures++; $display("[TB] FAIL single_memreq_msg got=%h exp=%h", memreq_msg, req); end
        checks++; if (imemreq_rdy !== 1'b1) begin failures++; $display("[TB] FAIL single_imemreq_rdy got=%b exp=1", imemreq_rdy); end
        checks++; if (dmemreq_rdy !== 1'b0) begin failures++; $display("[TB] FAIL single_dmemreq_rdy got=%b exp=0", dmemreq_rdy); end
        @(negedge clk);
        imemreq_val = 1'b0;
        #1;
        checks++; if (num_outst !== 3'd1) begin failures++; $display("[TB] FAIL single_num_outst got=%0d exp=1", num_outst); end
        memresp_msg = mk_resp(32'hDEAD_BEEF);
        memresp_val = 1'b1;
        #1;
        checks++; if (imemresp_val !== 1'b1) begin failures++; $display("[TB] FAIL single_imemresp_val got=%b exp=1", imemresp_val); end
        checks++; if (imemresp_msg !== mk_resp(32'hDEAD_BEEF)) begin failures++; $display("[TB] FAIL single_imemresp_msg got=%h exp=%h", imemresp_msg, mk_resp(32'hDEAD_BEEF)); end
        checks++; if (dmemresp_val !== 1'b0) begin failures++; $display("[TB] FAIL single_dmemresp_val got=%b exp=0", dmemresp_val); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL single_num_outst_after got=%0d exp=0", num_outst); end
    endtask

    // Both ports valid every cycle: grants alternate starting with dmem
    task automatic test_round_robin();
        logic [3:0] exp_dmem;
        logic [REQ_SZ-1:0] exp_msg;
        exp_dmem = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            dmemreq_msg = mk_req(1'b1, 32'h0000_2000 + 32'(i), 32'h0000_00D0 + 32'(i));
            imemreq_msg = mk_req(1'b0, 32'h0000_3000 + 32'(i), 32'h0);
            dmemreq_val = 1'b1;
            imemreq_val = 1'b1;
            memreq_rdy  = 1'b1;
            #1;
            exp_msg = exp_dmem[i] ? mk_req(1'b1, 32'h0000_2000 + 32'(i), 32'h0000_00D0 + 32'(i)) : mk_req(1'b0, 32'h0000_3000 + 32'(i), 32'h0);
            checks++; if (dmemreq_rdy !== exp_dmem[i]) begin failures++; $display("[TB] FAIL rr_grant%0d dmemreq_rdy got=%b exp=%b", i, dmemreq_rdy, exp_dmem[i]); end
            checks++; if (memreq_msg !== exp_msg) begin failures++; $display("[TB] FAIL rr_msg%0d got=%h exp=%h", i, memreq_msg, exp_msg); end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++; if (num_outst !== 3'd4) begin failures++; $display("[TB] FAIL rr_num_outst got=%0d exp=4", num_outst); end
        for (int i = 0; i < 4; i++) begin
            memresp_msg = mk_resp(32'h0000_0A00 + 32'(i));
            memresp_val = 1'b1;
            #1;
            checks++; if ({dmemresp_val, imemresp_val} !== {exp_dmem[i], !exp_dmem[i]}) begin failures++; $display("[TB] FAIL rr_route%0d d/i got=%b exp=%b", i, {dmemresp_val, imemresp_val}, {exp_dmem[i], !exp_dmem[i]}); end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL rr_drained got=%0d exp=0", num_outst); end
    endtask

    // Memory stalls: no grant side effects, priority held on dmem
    task automatic test_backpressure();
        dmemreq_msg = mk_req(1'b1, 32'h0000_4000, 32'h0);
        imemreq_msg = mk_req(1'b0, 32'h0000_5000, 32'h0);
        dmemreq_val = 1'b1;
        imemreq_val = 1'b1;
        memreq_rdy  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({dmemreq_rdy, imemreq_rdy} !== 2'b00) begin failures++; $display("[TB] FAIL bp_rdys%0d got=%b exp=00", i, {dmemreq_rdy, imemreq_rdy}); end
            checks++; if (memreq_msg !== mk_req(1'b1, 32'h0000_4000, 32'h0)) begin failures++; $display("[TB] FAIL bp_msg%0d got=%h exp=dmem", i, memreq_msg); end
            @(negedge clk);
        end
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL bp_num_outst got=%0d exp=0", num_outst); end
        memreq_rdy = 1'b1;
        #1;
        checks++; if ({dmemreq_rdy, imemreq_rdy} !== 2'b10) begin failures++; $display("[TB] FAIL bp_release got=%b exp=10", {dmemreq_rdy, imemreq_rdy}); end
        @(negedge clk);
        idle_inputs();
        memresp_msg = mk_resp(32'h0000_0B0B);
        memresp_val = 1'b1;
        #1;
        checks++; if (dmemresp_val !== 1'b1) begin failures++; $display("[TB] FAIL bp_resp dmemresp_val got=%b exp=1", dmemresp_val); end
        @(negedge clk);
        idle_inputs();
    endtask

    // Fill the tag FIFO; a pop does not unblock a push in the same cycle
    task automatic test_full();
        dmemreq_msg = mk_req(1'b1, 32'h0000_6000, 32'h0);
        dmemreq_val = 1'b1;
        memreq_rdy  = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (num_outst !== 3'd4) begin failures++; $display("[TB] FAIL full_num_outst got=%0d exp=4", num_outst); end
        checks++; if (dmemreq_rdy !== 1'b0) begin failures++; $display("[TB] FAIL full_dmemreq_rdy got=%b exp=0", dmemreq_rdy); end
        checks++; if (memreq_val !== 1'b0) begin failures++; $display("[TB] FAIL full_memreq_val got=%b exp=0", memreq_val); end
        memresp_msg = mk_resp(32'h0000_0C00);
        memresp_val = 1'b1;
        #1;
        checks++; if (dmemreq_rdy !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_no_bypass rdy got=%b exp=0", dmemreq_rdy); end
        checks++; if (dmemresp_val !== 1'b1) begin failures++; $display("[TB] FAIL full_pop dmemresp_val got=%b exp=1", dmemresp_val); end
        @(negedge clk);
        memresp_val = 1'b0;
        #1;
        checks++; if (num_outst !== 3'd3) begin failures++; $display("[TB] FAIL full_after_pop got=%0d exp=3", num_outst); end
        checks++; if (dmemreq_rdy !== 1'b1) begin failures++; $display("[TB] FAIL full_reaccept rdy got=%b exp=1", dmemreq_rdy); end
        @(negedge clk);
        dmemreq_val = 1'b0;
        #1;
        checks++; if (num_outst !== 3'd4) begin failures++; $display("[TB] FAIL full_refill got=%0d exp=4", num_outst); end
        for (int i = 0; i < 4; i++) begin
            memresp_val = 1'b1;
            #1;
            checks++; if ({dmemresp_val, imemresp_val} !== 2'b10) begin failures++; $display("[TB] FAIL full_drain%0d got=%b exp=10", i, {dmemresp_val, imemresp_val}); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // Simultaneous push/pop at count 2, then steady-state traffic wrapping the pointers
    task automatic test_push_pop_wrap();
        logic [13:0] pat;
        logic        exp_q[$];
        logic        exp_tag;
        imemreq_msg = mk_req(1'b0, 32'h0000_7000, 32'h0);
        imemreq_val = 1'b1;
        memreq_rdy  = 1'b1;
        @(negedge clk);
        imemreq_val = 1'b0;
        dmemreq_msg = mk_req(1'b1, 32'h0000_7100, 32'h0);
        dmemreq_val = 1'b1;
        @(negedge clk);
        dmemreq_val = 1'b0;
        imemreq_val = 1'b1;
        memresp_msg = mk_resp(32'h0000_0D00);
        memresp_val = 1'b1;
        #1;
        checks++; if ({dmemresp_val, imemresp_val} !== 2'b01) begin failures++; $display("[TB] FAIL pp_oldest got=%b exp=01", {dmemresp_val, imemresp_val}); end
        checks++; if (imemreq_rdy !== 1'b1) begin failures++; $display("[TB] FAIL pp_push_rdy got=%b exp=1", imemreq_rdy); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (num_outst !== 3'd2) begin failures++; $display("[TB] FAIL pp_num_outst got=%0d exp=2", num_outst); end
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        pat = 14'b10110011101001;
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            memreq_rdy = 1'b1;
            if (i < 14) begin
                imemreq_val = !pat[i];
                dmemreq_val = pat[i];
                imemreq_msg = mk_req(1'b0, 32'h0000_8000 + 32'(i), 32'h0);
                dmemreq_msg = mk_req(1'b1, 32'h0000_9000 + 32'(i), 32'h0);
            end
            memresp_msg = mk_resp(32'h0000_E000 + 32'(i));
            memresp_val = 1'b1;
            exp_tag = exp_q.pop_front();
            #1;
            checks++; if ({dmemresp_val, imemresp_val} !== {exp_tag, !exp_tag}) begin failures++; $display("[TB] FAIL wrap_route%0d got=%b exp=%b", i, {dmemresp_val, imemresp_val}, {exp_tag, !exp_tag}); end
            if (i < 14) begin
                exp_q.push_back(pat[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL wrap_drained got=%0d exp=0", num_outst); end
    endtask

    // Stray response sets a sticky error that only reset clears
    task automatic test_resp_err();
        memresp_msg = mk_resp(32'h0000_0F00);
        memresp_val = 1'b1;
        #1;
        checks++; if ({dmemresp_val, imemresp_val} !== 2'b00) begin failures++; $display("[TB] FAIL err_dropped got=%b exp=00", {dmemresp_val, imemresp_val}); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL err_not_yet got=%b exp=0", resp_err); end
        @(negedge clk);
        memresp_val = 1'b0;
        #1;
        checks++; if (resp_err !== 1'b1) begin failures++; $display("[TB] FAIL err_set got=%b exp=1", resp_err); end
        repeat (2) @(negedge clk);
        checks++; if (resp_err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky got=%b exp=1", resp_err); end
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL err_num_outst got=%0d exp=0", num_outst); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL err_cleared got=%b exp=0", resp_err); end
        checks++; if (num_outst !== 3'd0) begin failures++; $display("[TB] FAIL err_reset_num_outst got=%0d exp=0", num_outst); end
    endtask

    // Test sequence
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_imem();
        test_round_robin();
        test_backpressure();
        test_full();
        test_push_pop_wrap();
        test_resp_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
